if_stage: RTL and testbench
===========================

IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 SHALL have port: clk  in  1  system clock, all state on rising edge.
REQ-002 SHALL have port: rst  in  1  reset, asynchronous, active-low (0 = reset asserted).
REQ-003 SHALL have port: stall_in  in  1  hazard unit hold; IF/ID outputs frozen while 1.
REQ-004 SHALL have port: take_branch  in  1  redirect from EX; flushes fetch.
REQ-005 SHALL have port: branch_target  in  32  redirect PC; bits [1:0] ignored, forced 0.
REQ-006 SHALL have port: if_mem_req  out  1  instruction-memory request valid.
REQ-007 SHALL have port: if_mem_addr  out  32  word-aligned fetch address.
REQ-008 SHALL have port: mem_if_ack  in  1  response valid, any latency >= 1 cycle after request.
REQ-009 SHALL have port: mem_if_data  in  32  instruction word, valid when mem_if_ack=1.
REQ-010 SHALL have ports: if_id_IR  out  32, if_id_PC  out  32, if_id_valid_inst  out  1; IF/ID register feeding decode.

Function
REQ-011 SHALL keep at most one memory request outstanding; if_mem_addr and if_mem_req stable from assertion until the cycle mem_if_ack=1.
REQ-012 SHALL implement FSM states FETCH (req=1, awaiting ack), HOLD (skid full, req=0), SQUASH (req=1, awaiting ack of a dead request).
REQ-013 FETCH + ack + stall_in=0 + take_branch=0: next edge load if_id_IR=mem_if_data, if_id_PC=if_mem_addr, if_id_valid_inst=1; PC+=4; stay FETCH with new request next cycle.
REQ-014 FETCH + ack + stall_in=1: capture word/PC into 1-entry skid register, go HOLD; IF/ID unchanged.
REQ-015 HOLD + stall_in=0: move skid to IF/ID (valid=1), PC+=4, go FETCH.
REQ-016 Any cycle in which IF/ID is not stalled and no word is loaded: if_id_valid_inst=0, if_id_IR=32'h00000013 (NOP), if_id_PC unchanged.
REQ-017 stall_in=1 SHALL hold if_id_IR, if_id_PC, if_id_valid_inst exactly.
REQ-018 take_branch=1 SHALL have priority over stall_in and ack: next edge PC=branch_target, if_id_valid_inst=0, IR=NOP, skid invalidated.
REQ-019 take_branch in FETCH without ack (request in flight): go SQUASH; on its ack discard data, go FETCH at target.
REQ-020 take_branch in same cycle as ack: returned data discarded, next state FETCH, request to target next cycle.
REQ-021 take_branch in SQUASH: PC updated to newest target, remain SQUASH.
REQ-022 PC arithmetic modulo 2^32: 32'hFFFFFFFC + 4 = 32'h00000000.
REQ-023 Best-case throughput one instruction per cycle when memory acks in the cycle after request.

Reset
REQ-024 rst=0 SHALL immediately force: PC=0, state FETCH, skid invalid, if_id_IR=NOP, if_id_PC=0, if_id_valid_inst=0, if_mem_req=0.
REQ-025 First request (addr 0) SHALL issue in the first cycle after rst deasserts; an ack for a request outstanding at reset SHALL be ignored (SQUASH entered on release if ack pending is unknown is not required; memory is reset together).
REQ-026 Reset mid-transfer SHALL discard skid and in-flight word with no partial IF/ID update.

Configuration
REQ-027 Macro IF_FETCH_COUNT_EN defined: add output fetch_count  out  32, incremented on each edge loading IF/ID with valid=1, reset to 0, wraps at 2^32.
REQ-028 IF_FETCH_COUNT_EN undefined: port fetch_count and its counter absent; all other behaviour identical.

Verification
REQ-029 Reset release, memory acks next cycle with words W0..W3 -> IF/ID shows PC 0,4,8,12 valid on consecutive cycles.
REQ-030 Ack of PC 8 while stall_in=1 for 3 cycles -> IF/ID holds PC 4, if_mem_req=0 during HOLD, PC 8 valid one cycle after stall drops.
REQ-031 take_branch target 0x103 while request to 0x10 pending, ack 2 cycles later -> data for 0x10 never reaches IF/ID, next request addr 0x100.
REQ-032 take_branch with ack same cycle, stall_in=1 -> IF/ID valid=0 IR=0x00000013 next cycle, request to target.
REQ-033 branch_target 0xFFFFFFFC, sequential ack -> next fetch addr 0x00000000.
REQ-034 rst=0 asserted during HOLD -> outputs reset asynchronously; with IF_FETCH_COUNT_EN, fetch_count=0 and counts 4 after REQ-029 sequence.

Source files
------------

// File: rtl/if_stage.sv
// Instruction fetch stage: one-outstanding-request fetcher with a 1-entry skid and an IF/ID register.
// Latency: a word acked in cycle N is visible on IF/ID in cycle N+1; with 1-cycle memory this sustains 1 instr/cycle.
// Backpressure: stall_in freezes IF/ID; a word arriving under stall parks in the skid and the fetcher stops requesting.
//
// Ports:
//   clk, rst (async, active-low)          clock and reset
//   stall_in, take_branch, branch_target  hazard hold and EX redirect (target bits [1:0] dropped)
//   if_mem_req, if_mem_addr               request to instruction memory
//   mem_if_ack, mem_if_data               response from instruction memory
//   if_id_IR, if_id_PC, if_id_valid_inst  IF/ID register feeding decode
//   fetch_count                           count of valid IF/ID loads (only with IF_FETCH_COUNT_EN defined)
//
// Memory handshake: a request is issued at every rising edge where if_mem_req=1 and no earlier request is
// still unanswered. req/addr stay fixed until the ack cycle; during the ack cycle they already describe the
// next request (or req drops to 0 when nothing follows), which is what allows back-to-back fetches.
module if_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_in,
    input  logic        take_branch,
    input  logic [31:0] branch_target,
    output logic        if_mem_req,
    output logic [31:0] if_mem_addr,
    input  logic        mem_if_ack,
    input  logic [31:0] mem_if_data,
    output logic [31:0] if_id_IR,
    output logic [31:0] if_id_PC,
    output logic        if_id_valid_inst
`ifdef IF_FETCH_COUNT_EN
    ,
    output logic [31:0] fetch_count
`endif
);

    localparam logic [1:0]  ST_FETCH  = 2'd0;
    localparam logic [1:0]  ST_HOLD   = 2'd1;
    localparam logic [1:0]  ST_SQUASH = 2'd2;
    localparam logic [31:0] NOP       = 32'h0000_0013;

    logic [1:0]  r_state;
    logic [31:0] r_pc;        // address of the live fetch (or next fetch once a squash resolves)
    logic [31:0] r_sq_addr;   // address of the dead request being drained in SQUASH
    logic [31:0] r_skid_ir;   // parked word; its PC is r_pc, and it is valid exactly while in HOLD
    logic [31:0] r_id_ir;
    logic [31:0] r_id_pc;
    logic        r_id_vld;

    logic [1:0]  w_state_nxt;
    logic [31:0] w_pc_nxt;
    logic [31:0] w_sq_addr_nxt;
    logic [31:0] w_skid_nxt;
    logic        w_load;
    logic [31:0] w_load_ir;
    logic        w_req;
    logic [31:0] w_addr;
    logic [31:0] w_target;
    logic [31:0] w_pc_inc;

    assign w_target = branch_target & ~32'h0000_0003;
    assign w_pc_inc = r_pc + 32'd4;   // natural 32-bit wrap

    always_comb begin
        w_state_nxt   = r_state;
        w_pc_nxt      = r_pc;
        w_sq_addr_nxt = r_sq_addr;
        w_skid_nxt    = r_skid_ir;
        w_load        = 1'b0;
        w_load_ir     = mem_if_data;
        w_req         = 1'b0;
        w_addr        = r_pc;
        case (r_state)
            ST_FETCH: begin
                w_req = 1'b1;
                if (take_branch) begin
                    w_pc_nxt = w_target;
                    if (mem_if_ack) begin
                        // Word is dropped; target is requested from the next cycle.
                        w_req = 1'b0;
                    end else begin
                        // Request already in flight: keep it stable and drain it in SQUASH.
                        w_state_nxt   = ST_SQUASH;
                        w_sq_addr_nxt = r_pc;
                    end
                end else if (mem_if_ack) begin
                    if (stall_in) begin
                        w_req       = 1'b0;
                        w_state_nxt = ST_HOLD;
                        w_skid_nxt  = mem_if_data;
                    end else begin
                        w_load    = 1'b1;
                        w_load_ir = mem_if_data;
                        w_pc_nxt  = w_pc_inc;
                        w_addr    = w_pc_inc;   // next request issued in the ack cycle
                    end
                end
            end
            ST_HOLD: begin
                if (take_branch) begin
                    w_pc_nxt    = w_target;
                    w_state_nxt = ST_FETCH;
                end else if (!stall_in) begin
                    w_load      = 1'b1;
                    w_load_ir   = r_skid_ir;
                    w_pc_nxt    = w_pc_inc;
                    w_state_nxt = ST_FETCH;
                end
            end
            ST_SQUASH: begin
                w_req  = !mem_if_ack;
                w_addr = r_sq_addr;
                if (take_branch) begin
                    w_pc_nxt = w_target;
                end
                if (mem_if_ack) begin
                    w_state_nxt = ST_FETCH;
                end
            end
            default: begin
                w_state_nxt = ST_FETCH;
            end
        endcase
    end

    // Request is gated by reset directly so it drops the instant reset asserts.
    assign if_mem_req  = rst & w_req;
    assign if_mem_addr = w_addr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= ST_FETCH;
            r_pc      <= 32'd0;
            r_sq_addr <= 32'd0;
            r_skid_ir <= NOP;
        end else begin
            r_state   <= w_state_nxt;
            r_pc      <= w_pc_nxt;
            r_sq_addr <= w_sq_addr_nxt;
            r_skid_ir <= w_skid_nxt;
        end
    end

    // IF/ID: redirect clears it even under stall; otherwise stall holds it exactly.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_id_ir  <= NOP;
            r_id_pc  <= 32'd0;
            r_id_vld <= 1'b0;
        end else if (take_branch) begin
            r_id_ir  <= NOP;
            r_id_vld <= 1'b0;
        end else if (!stall_in) begin
            if (w_load) begin
                r_id_ir  <= w_load_ir;
                r_id_pc  <= r_pc;
                r_id_vld <= 1'b1;
            end else begin
                r_id_ir  <= NOP;
                r_id_vld <= 1'b0;
            end
        end
    end

    assign if_id_IR         = r_id_ir;
    assign if_id_PC         = r_id_pc;
    assign if_id_valid_inst = r_id_vld;

`ifdef IF_FETCH_COUNT_EN
    logic [31:0] r_fetch_cnt;

    // w_load is only ever set when neither redirect nor stall blocks the IF/ID load.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_fetch_cnt <= 32'd0;
        end else if (w_load) begin
            r_fetch_cnt <= r_fetch_cnt + 32'd1;
        end
    end

    assign fetch_count = r_fetch_cnt;
`endif

endmodule

// File: tb/tb_if_stage.sv
module tb_if_stage;

    logic        clk;
    logic        rst;
    logic        stall_in;
    logic        take_branch;
    logic [31:0] branch_target;
    logic        if_mem_req;
    logic [31:0] if_mem_addr;
    logic        mem_if_ack;
    logic [31:0] mem_if_data;
    logic [31:0] if_id_IR;
    logic [31:0] if_id_PC;
    logic        if_id_valid_inst;
`ifdef IF_FETCH_COUNT_EN
    logic [31:0] fetch_count;
`endif

    int checks   = 0;
    int failures = 0;
    int lat      = 1;

    localparam logic [31:0] NOP = 32'h0000_0013;

    if_stage dut (
        .clk             (clk),
        .rst             (rst),
        .stall_in        (stall_in),
        .take_branch     (take_branch),
        .branch_target   (branch_target),
        .if_mem_req      (if_mem_req),
        .if_mem_addr     (if_mem_addr),
        .mem_if_ack      (mem_if_ack),
        .mem_if_data     (mem_if_data),
        .if_id_IR        (if_id_IR),
        .if_id_PC        (if_id_PC),
        .if_id_valid_inst(if_id_valid_inst)
`ifdef IF_FETCH_COUNT_EN
        ,
        .fetch_count     (fetch_count)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] wrd(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    // Memory model: accepts a request at an edge when idle (or when its previous ack was in that cycle),
    // answers lat cycles later with wrd(addr). Reset together with the DUT.
    logic        s_req, s_ack, s_rst;
    logic [31:0] s_addr;
    bit          m_busy;
    int          m_cnt;
    logic [31:0] m_addr;
    initial begin
        mem_if_ack  = 1'b0;
        mem_if_data = 32'h0;
        m_busy      = 1'b0;
        m_cnt       = 0;
        m_addr      = 32'h0;
        forever begin
            @(negedge clk);
            s_req  = if_mem_req;
            s_addr = if_mem_addr;
            s_ack  = mem_if_ack;
            s_rst  = rst;
            @(posedge clk);
            #1;
            if (!s_rst) begin
                m_busy     = 1'b0;
                mem_if_ack = 1'b0;
            end else begin
                if (m_busy && s_ack) m_busy = 1'b0;
                if (s_req && !m_busy) begin
                    m_busy = 1'b1;
                    m_cnt  = lat;
                    m_addr = s_addr;
                end
                mem_if_ack = 1'b0;
                if (m_busy) begin
                    m_cnt = m_cnt - 1;
                    if (m_cnt == 0) mem_if_ack = 1'b1;
                end
            end
            mem_if_data = mem_if_ack ? wrd(m_addr) : 32'h0;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: sim time limit reached");
        $fatal(1, "timeout");
    end

    task automatic start_cycle;
        @(posedge clk);
        #1;
    endtask

    // Drops reset just after a rising edge; the cycle that follows is cycle 0.
    task automatic release_reset;
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic enter_reset;
        rst         = 1'b0;
        stall_in    = 1'b0;
        take_branch = 1'b0;
        lat         = 1;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_reset;
        rst           = 1'b0;
        stall_in      = 1'b0;
        take_branch   = 1'b0;
        branch_target = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (if_id_valid_inst !== 1'b0) begin failures++; $display("FAIL reset_vld: got %b want 0", if_id_valid_inst); end
        checks++; if (if_id_IR !== NOP) begin failures++; $display("FAIL reset_ir: got %h want %h", if_id_IR, NOP); end
        checks++; if (if_id_PC !== 32'h0) begin failures++; $display("FAIL reset_pc: got %h want 0", if_id_PC); end
        checks++; if (if_mem_req !== 1'b0) begin failures++; $display("FAIL reset_req: got %b want 0", if_mem_req); end
`ifdef IF_FETCH_COUNT_EN
        checks++; if (fetch_count !== 32'h0) begin failures++; $display("FAIL reset_cnt: got %0d want 0", fetch_count); end
`endif
    endtask

    task automatic test_sequential;
        enter_reset();
        release_reset();
        @(negedge clk);
        checks++; if (if_mem_req !== 1'b1 || if_mem_addr !== 32'h0) begin failures++; $display("FAIL seq_first_req: got req=%b addr=%h want 1/0", if_mem_req, if_mem_addr); end
        start_cycle(); @(negedge clk);
        checks++; if (if_id_valid_inst !== 1'b0) begin failures++; $display("FAIL seq_c1_vld: got %b want 0", if_id_valid_inst); end
        for (int i = 0; i < 4; i++) begin
            start_cycle(); @(negedge clk);
            checks++;
            if (if_id_valid_inst !== 1'b1 || if_id_PC !== 32'(4 * i) || if_id_IR !== wrd(32'(4 * i))) begin
                failures++;
                $display("FAIL seq_word%0d: got vld=%b pc=%h ir=%h want 1/%h/%h", i, if_id_valid_inst, if_id_PC, if_id_IR, 32'(4 * i), wrd(32'(4 * i)));
            end
        end
`ifdef IF_FETCH_COUNT_EN
        checks++; if (fetch_count !== 32'd4) begin failures++; $display("FAIL seq_cnt: got %0d want 4", fetch_count); end
`endif
    endtask

    task automatic test_stall;
        enter_reset();
        release_reset();
        start_cycle(); start_cycle();
        start_cycle(); stall_in = 1'b1; @(negedge clk);   // cycle 3: ack of PC 8 under stall
        checks++; if (if_mem_req !== 1'b0) begin failures++; $display("FAIL stall_ack_req: got %b want 0", if_mem_req); end
        for (int c = 4; c <= 5; c++) begin
            start_cycle(); @(negedge clk);
            checks++;
            if (if_mem_req !== 1'b0 || if_id_valid_inst !== 1'b1 || if_id_PC !== 32'h4) begin
                failures++;
                $display("FAIL stall_hold_c%0d: got req=%b vld=%b pc=%h want 0/1/4", c, if_mem_req, if_id_valid_inst, if_id_PC);
            end
        end
        start_cycle(); stall_in = 1'b0; @(negedge clk);
        checks++; if (if_id_PC !== 32'h4 || if_id_IR !== wrd(32'h4)) begin failures++; $display("FAIL stall_drop_hold: got pc=%h ir=%h want 4/%h", if_id_PC, if_id_IR, wrd(32'h4)); end
        start_cycle(); @(negedge clk);
        checks++; if (if_id_valid_inst !== 1'b1 || if_id_PC !== 32'h8 || if_id_IR !== wrd(32'h8)) begin failures++; $display("FAIL stall_skid_out: got vld=%b pc=%h ir=%h want 1/8/%h", if_id_valid_inst, if_id_PC, if_id_IR, wrd(32'h8)); end
        checks++; if (if_mem_req !== 1'b1 || if_mem_addr !== 32'hC) begin failures++; $display("FAIL stall_next_req: got req=%b addr=%h want 1/c", if_mem_req, if_mem_addr); end
        start_cycle(); @(negedge clk);
        checks++; if (if_id_valid_inst !== 1'b0 || if_id_IR !== NOP || if_id_PC !== 32'h8) begin failures++; $display("FAIL stall_bubble: got vld=%b ir=%h pc=%h want 0/13/8", if_id_valid_inst, if_id_IR, if_id_PC); end
        start_cycle(); @(negedge clk);
        checks++; if (if_id_valid_inst !== 1'b1 || if_id_PC !== 32'hC) begin failures++; $display("FAIL stall_resume: got vld=%b pc=%h want 1/c", if_id_valid_inst, if_id_PC); end
    endtask

    task automatic test_reset_in_hold;
        enter_reset();
        release_reset();
        start_cycle(); start_cycle();
        start_cycle(); stall_in = 1'b1;
        start_cycle(); @(negedge clk);   // cycle 4: HOLD with PC 8 parked
        #1 rst = 1'b0;
        #1;
        checks++; if (if_id_valid_inst !== 1'b0 || if_id_IR !== NOP || if_id_PC !== 32'h0) begin failures++; $display("FAIL rsthold_idid: got vld=%b ir=%h pc=%h want 0/13/0", if_id_valid_inst, if_id_IR, if_id_PC); end
        checks++; if (if_mem_req !== 1'b0) begin failures++; $display("FAIL rsthold_req: got %b want 0", if_mem_req); end
`ifdef IF_FETCH_COUNT_EN
        checks++; if (fetch_count !== 32'h0) begin failures++; $display("FAIL rsthold_cnt: got %0d want 0", fetch_count); end
`endif
        stall_in = 1'b0;
        release_reset();
        @(negedge clk);
        checks++; if (if_mem_req !== 1'b1 || if_mem_addr !== 32'h0) begin failures++; $display("FAIL rsthold_restart: got req=%b addr=%h want 1/0", if_mem_req, if_mem_addr); end
        start_cycle(); start_cycle(); @(negedge clk);
        checks++; if (if_id_valid_inst !== 1'b1 || if_id_PC !== 32'h0 || if_id_IR !== wrd(32'h0)) begin failures++; $display("FAIL rsthold_first: got vld=%b pc=%h ir=%h want 1/0/%h", if_id_valid_inst, if_id_PC, if_id_IR, wrd(32'h0)); end
    endtask

    task automatic test_branch_inflight;
        enter_reset();
        release_reset();
        repeat (4) start_cycle();
        @(negedge clk);   // cycle 4: request to 0x10 presented
        checks++; if (if_mem_addr !== 32'h10 || if_mem_req !== 1'b1) begin failures++; $display("FAIL bri_req10: got req=%b addr=%h want 1/10", if_mem_req, if_mem_addr); end
        lat = 3;
        start_cycle(); take_branch = 1'b1; branch_target = 32'h103;
        start_cycle(); take_branch = 1'b0; @(negedge clk);
        lat = 1;
        checks++; if (if_id_valid_inst !== 1'b0 || if_id_IR !== NOP || if_id_PC !== 32'hC) begin failures++; $display("FAIL bri_flush: got vld=%b ir=%h pc=%h want 0/13/c", if_id_valid_inst, if_id_IR, if_id_PC); end
        checks++; if (if_mem_req !== 1'b1 || if_mem_addr !== 32'h10) begin failures++; $display("FAIL bri_stable: got req=%b addr=%h want 1/10", if_mem_req, if_mem_addr); end
        for (int c = 7; c <= 9; c++) begin
            start_cycle(); @(negedge clk);
            checks++; if (if_id_valid_inst !== 1'b0) begin failures++; $display("FAIL bri_dead_c%0d: got vld=%b pc=%h want 0", c, if_id_valid_inst, if_id_PC); end
            if (c == 8) begin
                checks++; if (if_mem_req !== 1'b1 || if_mem_addr !== 32'h100) begin failures++; $display("FAIL bri_target_req: got req=%b addr=%h want 1/100", if_mem_req, if_mem_addr); end
            end
        end
        start_cycle(); @(negedge clk);
        checks++; if (if_id_valid_inst !== 1'b1 || if_id_PC !== 32'h100 || if_id_IR !== wrd(32'h100)) begin failures++; $display("FAIL bri_target_word: got vld=%b pc=%h ir=%h want 1/100/%h", if_id_valid_inst, if_id_PC, if_id_IR, wrd(32'h100)); end
    endtask

    task automatic test_branch_ack_stall;
        enter_reset();
        release_reset();
        start_cycle();
        start_cycle(); take_branch = 1'b1; stall_in = 1'b1; branch_target = 32'h200;
        start_cycle(); take_branch = 1'b0; stall_in = 1'b0; @(negedge clk);
        checks++; if (if_id_valid_inst !== 1'b0 || if_id_IR !== NOP || if_id_PC !== 32'h0) begin failures++; $display("FAIL bas_flush: got vld=%b ir=%h pc=%h want 0/13/0", if_id_valid_inst, if_id_IR, if_id_PC); end
        checks++; if (if_mem_req !== 1'b1 || if_mem_addr !== 32'h200) begin failures++; $display("FAIL bas_req: got req=%b addr=%h want 1/200", if_mem_req, if_mem_addr); end
        start_cycle(); start_cycle(); @(negedge clk);
        checks++; if (if_id_valid_inst !== 1'b1 || if_id_PC !== 32'h200) begin failures++; $display("FAIL bas_word: got vld=%b pc=%h want 1/200", if_id_valid_inst, if_id_PC); end
    endtask

    task automatic test_wrap;
        enter_reset();
        release_reset();
        start_cycle();
        start_cycle(); take_branch = 1'b1; branch_target = 32'hFFFF_FFFF;
        start_cycle(); take_branch = 1'b0; @(negedge clk);
        checks++; if (if_mem_addr !== 32'hFFFF_FFFC || if_mem_req !== 1'b1) begin failures++; $display("FAIL wrap_target: got req=%b addr=%h want 1/fffffffc", if_mem_req, if_mem_addr); end
        start_cycle(); @(negedge clk);
        checks++; if (if_mem_addr !== 32'h0 || if_mem_req !== 1'b1) begin failures++; $display("FAIL wrap_next: got req=%b addr=%h want 1/0", if_mem_req, if_mem_addr); end
        start_cycle(); @(negedge clk);
        checks++; if (if_id_valid_inst !== 1'b1 || if_id_PC !== 32'hFFFF_FFFC || if_id_IR !== wrd(32'hFFFF_FFFC)) begin failures++; $display("FAIL wrap_word_top: got vld=%b pc=%h ir=%h", if_id_valid_inst, if_id_PC, if_id_IR); end
        start_cycle(); @(negedge clk);
        checks++; if (if_id_valid_inst !== 1'b1 || if_id_PC !== 32'h0) begin failures++; $display("FAIL wrap_word_zero: got vld=%b pc=%h want 1/0", if_id_valid_inst, if_id_PC); end
    endtask

    initial begin
        rst           = 1'b0;
        stall_in      = 1'b0;
        take_branch   = 1'b0;
        branch_target = 32'h0;
        test_reset();
        test_sequential();
        test_stall();
        test_reset_in_hold();
        test_branch_inflight();
        test_branch_ack_stall();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
